// File: rtl/cpu4_dmem_resp.sv
// rtl/cpu4_dmem_resp.sv - cpu4 data-memory responder with wait states; optional debug register via CPU4_DMEM_DBGREG_EN
module cpu4_dmem_resp #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] dbg_out
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wmask_q, wmask_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic [31:0] mem [DEPTH];

  logic [AW-1:0] idx;
  logic          misaligned;
  logic          out_of_range;
  logic          in_range;
  logic          is_dbg;
  logic          acc_err;
  logic          access;
  logic          mem_we;
  logic [31:0]   rd_word;

  // The access is decoded only from the latched request, never from live inputs.
  assign idx          = addr_q[AW+1:2];
  assign misaligned   = (addr_q[1:0] != 2'b00);
  assign out_of_range = (addr_q[31:AW+2] != '0);
  assign in_range     = ~misaligned & ~out_of_range;
  assign access       = (state_q == BUSY) && (cnt_q == 4'd0);
  assign mem_we       = access & we_q & in_range;

`ifdef CPU4_DMEM_DBGREG_EN
  logic [31:0] dbg_q;

  assign is_dbg  = (addr_q == 32'hFFFF_FFFC);
  assign rd_word = in_range ? mem[idx] : (is_dbg ? dbg_q : 32'd0);
  assign dbg_out = dbg_q;

  // Debug register: byte-masked write on the same access edge as the array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbg_q <= 32'd0;
    end else if (access && we_q && is_dbg) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask_q[b]) dbg_q[8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end
`else
  assign is_dbg  = 1'b0;
  assign rd_word = in_range ? mem[idx] : 32'd0;
  assign dbg_out = 32'd0;
`endif

  assign acc_err = ~(in_range | is_dbg);

  // Array write port: contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask_q[b]) mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  // State, wait counter, latched request and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      wmask_q     <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Next-state logic: accept in IDLE, count down in BUSY, hold the response in RESP.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wmask_d = req_wmask;
          cnt_d   = WAIT_INIT;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = acc_err;
          rsp_rdata_d = (acc_err || we_q) ? 32'd0 : rd_word;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_cpu4_dmem_resp.sv
// tb/tb_cpu4_dmem_resp.sv - self-checking bench for cpu4_dmem_resp (honours CPU4_DMEM_DBGREG_EN)
module tb_cpu4_dmem_resp;

  localparam int DEPTH = 256;
`ifdef CPU4_DMEM_DBGREG_EN
  localparam bit DBG_EN = 1'b1;
`else
  localparam bit DBG_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst1_n = 1'b0;
  logic        rst3_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [3:0]  req_wmask = 4'd0;
  logic        rsp_ready = 1'b0;

  logic        rdy1, rv1, er1, rdy3, rv3, er3;
  logic [31:0] rd1, dbg1, rd3, dbg3;

  logic        sel3 = 1'b0;
  logic        cur_rdy, cur_rv, cur_er;
  logic [31:0] cur_rd;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_model [DEPTH];
  logic [31:0] dbg_model = 32'd0;

  always #5 clk = ~clk;

  cpu4_dmem_resp #(.DEPTH(DEPTH), .WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst1_n), .req_valid(req_valid), .req_ready(rdy1),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rv1), .rsp_ready(rsp_ready), .rsp_rdata(rd1), .rsp_err(er1), .dbg_out(dbg1)
  );

  cpu4_dmem_resp #(.DEPTH(DEPTH), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst3_n), .req_valid(req_valid), .req_ready(rdy3),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rv3), .rsp_ready(rsp_ready), .rsp_rdata(rd3), .rsp_err(er3), .dbg_out(dbg3)
  );

  always_comb begin
    cur_rdy = sel3 ? rdy3 : rdy1;
    cur_rv  = sel3 ? rv3  : rv1;
    cur_rd  = sel3 ? rd3  : rd1;
    cur_er  = sel3 ? er3  : er1;
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] m);
    logic [31:0] bm;
    bm = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    return (old & ~bm) | (wd & bm);
  endfunction

  // Reference: legal iff word-aligned and below DEPTH*4 (or the debug address when enabled).
  task automatic model_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] m, output logic [31:0] exp_rd, output logic exp_err);
    bit in_range, is_dbg;
    in_range = (addr % 4 == 0) && (addr < DEPTH * 4);
    is_dbg   = DBG_EN && (addr == 32'hFFFF_FFFC);
    exp_err  = !(in_range || is_dbg);
    exp_rd   = 32'd0;
    if (we) begin
      if (in_range) mem_model[addr / 4] = merge(mem_model[addr / 4], wd, m);
      if (is_dbg)   dbg_model = merge(dbg_model, wd, m);
    end else if (in_range) begin
      exp_rd = mem_model[addr / 4];
    end else if (is_dbg) begin
      exp_rd = dbg_model;
    end
  endtask

  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] m, input int exp_lat,
                        output logic [31:0] rdata, output logic err);
    int  n;
    bit  got;
    rdata = 32'hxxxx_xxxx;
    err   = 1'bx;
    @(negedge clk);
    req_we = we; req_addr = addr; req_wdata = wd; req_wmask = m;
    req_valid = 1'b1; rsp_ready = 1'b1;
    got = 0; n = 0;
    while (!got && n < 50) begin
      if (cur_rdy) got = 1;
      else begin @(negedge clk); n++; end
    end
    if (!got) begin
      timeout("accept");
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    got = 0; n = 0;
    while (!got && n < 50) begin
      @(posedge clk); n++; #1;
      if (cur_rv) got = 1;
    end
    if (!got) begin
      timeout("rsp_valid");
      return;
    end
    check("latency", 32'(n), 32'(exp_lat));
    rdata = cur_rd;
    err   = cur_er;
    @(posedge clk); #1;
  endtask

  vec_t        vecs[$];
  logic [31:0] rd, exp_rd, held_rd;
  logic        er, exp_er, held_er;
  int          n;
  bit          got;

  initial begin
    // Directed vectors; expectations written from the functional rules.
    vecs.push_back('{1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{1'b1, 32'h10,  32'h11223344, 4'h5, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 32'h10,  32'h0,        4'h0, 32'hDE22BE44, 1'b0});
    vecs.push_back('{1'b0, 32'h12,  32'h0,        4'h0, 32'h0,        1'b1});
    vecs.push_back('{1'b0, 32'h400, 32'h0,        4'h0, 32'h0,        1'b1});
    vecs.push_back('{1'b0, 32'h10,  32'h0,        4'h0, 32'hDE22BE44, 1'b0});
    vecs.push_back('{1'b1, 32'h14,  32'hFFFFFFFF, 4'h0, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 32'h14,  32'h0,        4'h0, 32'hA5000005, 1'b0});
    vecs.push_back('{1'b1, 32'h3FC, 32'h0BADF00D, 4'hF, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 32'h3FC, 32'h0,        4'h0, 32'h0BADF00D, 1'b0});
    vecs.push_back('{1'b1, 32'h13,  32'h0,        4'hF, 32'h0,        1'b1});
    vecs.push_back('{1'b0, 32'h10,  32'h0,        4'h0, 32'hDE22BE44, 1'b0});
    vecs.push_back('{1'b1, 32'h404, 32'h0,        4'hF, 32'h0,        1'b1});
    vecs.push_back('{1'b0, 32'h4,   32'h0,        4'h0, 32'hA5000001, 1'b0});
    vecs.push_back('{1'b1, 32'hFFFFFFFC, 32'h000000A5, 4'h1, 32'h0, !DBG_EN});
    vecs.push_back('{1'b0, 32'hFFFFFFFC, 32'h0, 4'h0, DBG_EN ? 32'hA5 : 32'h0, !DBG_EN});

    // Reset state of the WAIT_CYCLES=1 instance.
    repeat (2) @(posedge clk);
    #1;
    check("reset req_ready", {31'd0, rdy1}, 32'd1);
    check("reset rsp_valid", {31'd0, rv1}, 32'd0);
    check("reset rsp_rdata", rd1, 32'd0);
    check("reset rsp_err",   {31'd0, er1}, 32'd0);
    check("reset dbg_out",   dbg1, 32'd0);
    @(negedge clk);
    rst1_n = 1'b1;

    // Initialise every word so that any later read has a defined value.
    for (int i = 0; i < DEPTH; i++) begin
      do_txn(1'b1, 32'(i * 4), 32'hA500_0000 | 32'(i), 4'hF, 2, rd, er);
      model_txn(1'b1, 32'(i * 4), 32'hA500_0000 | 32'(i), 4'hF, exp_rd, exp_er);
    end

    // Table-driven vectors.
    for (int v = 0; v < vecs.size(); v++) begin
      do_txn(vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].wmask, 2, rd, er);
      model_txn(vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].wmask, exp_rd, exp_er);
      check($sformatf("vec%0d rdata", v), rd, vecs[v].exp_rd);
      check($sformatf("vec%0d err", v), {31'd0, er}, {31'd0, vecs[v].exp_err});
    end
    check("dbg_out after debug write", dbg1, DBG_EN ? 32'h000000A5 : 32'h0);

    // Back-pressure: response held stable while rsp_ready is low.
    @(negedge clk);
    req_we = 1'b0; req_addr = 32'h10; req_valid = 1'b1; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    got = 0; n = 0;
    while (!got && n < 20) begin
      @(posedge clk); n++; #1;
      if (rv1) got = 1;
    end
    if (!got) timeout("stall rsp_valid");
    held_rd = rd1;
    held_er = er1;
    check("stall rdata", held_rd, 32'hDE22BE44);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("stall rsp_valid", {31'd0, rv1}, 32'd1);
      check("stall rdata stable", rd1, held_rd);
      check("stall err stable", {31'd0, er1}, {31'd0, held_er});
      check("stall req_ready", {31'd0, rdy1}, 32'd0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("release rsp_valid", {31'd0, rv1}, 32'd0);
    check("release req_ready", {31'd0, rdy1}, 32'd1);

    // Randomized traffic against the reference model.
    for (int t = 0; t < 250; t++) begin
      logic        we;
      logic [31:0] addr, wd;
      logic [3:0]  m;
      int          r;
      r    = $urandom_range(0, 9);
      we   = 1'($urandom_range(0, 1));
      wd   = $urandom;
      m    = 4'($urandom_range(0, 15));
      addr = 32'($urandom_range(0, DEPTH - 1)) << 2;
      if (r == 7) addr = addr | 32'($urandom_range(1, 3));
      else if (r == 8) addr = 32'(DEPTH * 4) + (32'($urandom_range(0, 1000)) << 2);
      else if (r == 9) addr = (r[0] ? 32'hFFFF_FFFC : ($urandom | 32'h8000_0000));
      do_txn(we, addr, wd, m, 2, rd, er);
      model_txn(we, addr, wd, m, exp_rd, exp_er);
      check($sformatf("rand%0d rdata @%08h", t, addr), rd, exp_rd);
      check($sformatf("rand%0d err @%08h", t, addr), {31'd0, er}, {31'd0, exp_er});
    end
    check("dbg_out final", dbg1, dbg_model);

    // Reset during BUSY on the WAIT_CYCLES=3 instance drops the pending write.
    @(negedge clk);
    rst1_n = 1'b0;
    sel3   = 1'b1;
    @(negedge clk);
    rst3_n = 1'b1;
    do_txn(1'b1, 32'h20, 32'h12345678, 4'hF, 4, rd, er);
    check("w3 prior err", {31'd0, er}, 32'd0);
    do_txn(1'b0, 32'h20, 32'h0, 4'h0, 4, rd, er);
    check("w3 prior rdata", rd, 32'h12345678);
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_wmask = 4'hF;
    req_valid = 1'b1;
    check("w3 ready before accept", {31'd0, rdy3}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    check("w3 busy", {31'd0, rdy3}, 32'd0);
    rst3_n = 1'b0;
    #1;
    check("w3 reset rsp_valid", {31'd0, rv3}, 32'd0);
    @(negedge clk);
    rst3_n = 1'b1;
    @(posedge clk); #1;
    check("w3 after release rsp_valid", {31'd0, rv3}, 32'd0);
    check("w3 after release req_ready", {31'd0, rdy3}, 32'd1);
    do_txn(1'b0, 32'h20, 32'h0, 4'h0, 4, rd, er);
    check("w3 dropped write rdata", rd, 32'h12345678);
    check("w3 dropped write err", {31'd0, er}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
